// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl_pkg.sv
// Source codes, controller FSM states and a small decode helper shared by
// the DAC source controller and its per-channel mux.
package ad_ip_jesd204_tpl_dac_src_ctrl_pkg;

    localparam logic [3:0] SRC_DMA  = 4'd0;
    localparam logic [3:0] SRC_ZERO = 4'd1;
    localparam logic [3:0] SRC_PN7  = 4'd2;
    localparam logic [3:0] SRC_PN15 = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } src_state_e;

    function automatic logic is_pn(input logic [3:0] code);
        return (code == SRC_PN7) || (code == SRC_PN15);
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl_if.sv
// Configuration, PN generator, DMA and framer-side signals of the DAC source
// controller; master drives configuration/data, slave is the controller.
interface ad_ip_jesd204_tpl_dac_src_ctrl_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int DW           = 64
);
    logic [4*NUM_CHANNELS-1:0]  cfg_sel;
    logic                       cfg_update;
    logic                       cfg_sync_en;
    logic                       ext_sync;
    logic                       cfg_busy;
    logic [4*NUM_CHANNELS-1:0]  sel_active;
    logic                       pn_reset;
    logic [DW-1:0]              pn7_data;
    logic [DW-1:0]              pn15_data;
    logic [DW*NUM_CHANNELS-1:0] dma_data;
    logic                       dma_rd;
    logic [DW*NUM_CHANNELS-1:0] dac_data;
    logic                       dac_valid;

    modport master (
        output cfg_sel, cfg_update, cfg_sync_en, ext_sync,
        output pn7_data, pn15_data, dma_data,
        input  cfg_busy, sel_active, pn_reset, dma_rd, dac_data, dac_valid
    );

    modport slave (
        input  cfg_sel, cfg_update, cfg_sync_en, ext_sync,
        input  pn7_data, pn15_data, dma_data,
        output cfg_busy, sel_active, pn_reset, dma_rd, dac_data, dac_valid
    );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl_mux.sv
// One channel's source select: DMA slice, zero or a PN word, registered.
// Latency 1 clk; no backpressure, reserved codes decode as zero.
module ad_ip_jesd204_tpl_dac_src_ctrl_mux
    import ad_ip_jesd204_tpl_dac_src_ctrl_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic [3:0]    i_sel,
    input  logic [DW-1:0] i_dma,
    input  logic [DW-1:0] i_pn7,
    input  logic [DW-1:0] i_pn15,
    output logic [DW-1:0] o_data
);

    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;

    always_comb begin
        w_data = '0;
        case (i_sel)
            SRC_DMA:  w_data = i_dma;
            SRC_PN7:  w_data = i_pn7;
            SRC_PN15: w_data = i_pn15;
            default:  w_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_data <= '0;
        end else begin
            r_data <= w_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_src_ctrl.sv
// Per-channel DAC source controller: atomic, optionally sync-aligned source
// switch with PN reseed. Data latency 1 clk; no backpressure, dma_rd is a pull strobe.
module ad_ip_jesd204_tpl_dac_src_ctrl
    import ad_ip_jesd204_tpl_dac_src_ctrl_pkg::*;
#(
    parameter int NUM_CHANNELS         = 2,
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16
) (
    input  logic                             i_clk,
    input  logic                             i_resetn,
    ad_ip_jesd204_tpl_dac_src_ctrl_if.slave  bus
);

    localparam int DW = DATA_PATH_WIDTH * CONVERTER_RESOLUTION;
    localparam int SW = 4 * NUM_CHANNELS;

    src_state_e              r_state;
    src_state_e              w_state_nxt;
    logic [SW-1:0]           r_pending;
    logic [SW-1:0]           r_active;
    logic                    r_out_en;
    logic                    r_valid;
    logic                    w_capture;
    logic                    w_busy;
    logic                    w_pn_reset;
    logic                    w_reseed;
    logic                    w_dma_any;
    logic [DW*NUM_CHANNELS-1:0] w_dac;

    // The PN generator is shared, so one switching channel reseeds every PN channel.
    always_comb begin
        w_reseed  = 1'b0;
        w_dma_any = 1'b0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (is_pn(r_pending[4*ch +: 4]) && (r_pending[4*ch +: 4] != r_active[4*ch +: 4]))
                w_reseed = 1'b1;
            if (r_active[4*ch +: 4] == SRC_DMA)
                w_dma_any = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_busy      = 1'b0;
        w_pn_reset  = ~r_out_en;
        case (r_state)
            ST_IDLE: begin
                if (bus.cfg_update) begin
                    w_capture   = 1'b1;
                    w_state_nxt = bus.cfg_sync_en ? ST_ARMED : ST_APPLY;
                end
            end
            ST_ARMED: begin
                w_busy = 1'b1;
                // A fresh request replaces the pending one and restarts the sync wait.
                if (bus.cfg_update) begin
                    w_capture   = 1'b1;
                    w_state_nxt = bus.cfg_sync_en ? ST_ARMED : ST_APPLY;
                end else if (bus.ext_sync) begin
                    w_state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                w_busy      = 1'b1;
                w_pn_reset  = ~r_out_en | w_reseed;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_pending <= {NUM_CHANNELS{SRC_ZERO}};
            r_active  <= {NUM_CHANNELS{SRC_ZERO}};
            r_out_en  <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            r_valid  <= r_out_en;
            if (w_capture)
                r_pending <= bus.cfg_sel;
            if (r_state == ST_APPLY)
                r_active <= r_pending;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        ad_ip_jesd204_tpl_dac_src_ctrl_mux #(
            .DW (DW)
        ) u_mux (
            .i_clk    (i_clk),
            .i_resetn (i_resetn),
            .i_sel    (r_active[4*g +: 4]),
            .i_dma    (bus.dma_data[DW*g +: DW]),
            .i_pn7    (bus.pn7_data),
            .i_pn15   (bus.pn15_data),
            .o_data   (w_dac[DW*g +: DW])
        );
    end

    assign bus.cfg_busy   = w_busy;
    assign bus.pn_reset   = w_pn_reset;
    assign bus.sel_active = r_active;
    assign bus.dma_rd     = w_dma_any;
    assign bus.dac_data   = w_dac;
    assign bus.dac_valid  = r_valid;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_src_ctrl.sv
// Bench for the DAC source controller: directed scenarios plus a random run,
// all compared against a request-level model of source switching.
module tb_ad_ip_jesd204_tpl_dac_src_ctrl;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    ad_ip_jesd204_tpl_dac_src_ctrl_if #(.NUM_CHANNELS(2), .DW(64)) b();

    ad_ip_jesd204_tpl_dac_src_ctrl #(
        .NUM_CHANNELS(2), .DATA_PATH_WIDTH(4), .CONVERTER_RESOLUTION(16)
    ) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (b)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Model: m_wait = request waiting for sync, m_go = apply happens at the coming edge.
    bit         m_en, m_valid, m_wait, m_go;
    logic [7:0]   m_pend, m_act;
    logic [127:0] m_dac;

    function automatic logic [63:0] expect_word(input logic [3:0] code, input logic [63:0] pn7,
                                                input logic [63:0] pn15, input logic [63:0] dma);
        if (code == 4'd0) return dma;
        if (code == 4'd2) return pn7;
        if (code == 4'd3) return pn15;
        return 64'd0;
    endfunction

    function automatic bit needs_seed();
        for (int c = 0; c < 2; c++) begin
            if ((m_pend[4*c +: 4] == 4'd2 || m_pend[4*c +: 4] == 4'd3) && m_pend[4*c +: 4] != m_act[4*c +: 4])
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_pnrst();
        return !m_en || (m_go && needs_seed());
    endfunction

    function automatic bit exp_dmard();
        return (m_act[3:0] == 4'd0) || (m_act[7:4] == 4'd0);
    endfunction

    task automatic model_reset();
        m_en = 0; m_valid = 0; m_wait = 0; m_go = 0;
        m_pend = 8'h11; m_act = 8'h11; m_dac = '0;
    endtask

    // Advance one clock; the stand-in PN generator emits its all-ones seed after a pn_reset cycle.
    task automatic tick();
        logic [127:0] nd;
        logic [7:0]   np, na;
        bit           pr, nw, ng;
        pr = exp_pnrst();
        for (int c = 0; c < 2; c++)
            nd[64*c +: 64] = expect_word(m_act[4*c +: 4], b.pn7_data, b.pn15_data, b.dma_data[64*c +: 64]);
        np = m_pend; na = m_act; nw = m_wait; ng = 0;
        if (m_go) begin
            na = m_pend;
        end else if (b.cfg_update) begin
            np = b.cfg_sel; nw = b.cfg_sync_en; ng = !b.cfg_sync_en;
        end else if (m_wait && b.ext_sync) begin
            nw = 0; ng = 1;
        end
        @(posedge clk); #1;
        m_dac = nd; m_valid = m_en; m_en = 1;
        m_pend = np; m_act = na; m_wait = nw; m_go = ng;
        b.pn7_data  = pr ? '1 : {$urandom(), $urandom()};
        b.pn15_data = pr ? '1 : {$urandom(), $urandom()};
        b.dma_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        resetn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 resetn = 1;
        n_chk++; if (b.sel_active !== 8'h11) begin n_fail++; $display("FAIL reset_sel_active got %h exp 11", b.sel_active); end
        n_chk++; if (b.dac_data !== 128'd0) begin n_fail++; $display("FAIL reset_dac_data got %h exp 0", b.dac_data); end
        n_chk++; if (b.pn_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pn_reset got %b exp 1", b.pn_reset); end
        n_chk++; if (b.dac_valid !== 1'b0 || b.dma_rd !== 1'b0 || b.cfg_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got valid=%b rd=%b busy=%b exp 0/0/0", b.dac_valid, b.dma_rd, b.cfg_busy); end
        tick();
        n_chk++; if (b.pn_reset !== 1'b0 || b.dac_valid !== 1'b0) begin
            n_fail++; $display("FAIL edge1 got pn_reset=%b valid=%b exp 0/0", b.pn_reset, b.dac_valid); end
        tick();
        n_chk++; if (b.dac_valid !== 1'b1) begin n_fail++; $display("FAIL edge2_valid got %b exp 1", b.dac_valid); end
    endtask

    task automatic test_pn7_switch();
        b.cfg_sel = 8'h22; b.cfg_sync_en = 0; b.cfg_update = 1;
        tick();
        b.cfg_update = 0;
        n_chk++; if (b.pn_reset !== 1'b1 || b.cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL pn7_apply got pn_reset=%b busy=%b exp 1/1", b.pn_reset, b.cfg_busy); end
        tick();
        n_chk++; if (b.sel_active !== 8'h22) begin n_fail++; $display("FAIL pn7_sel got %h exp 22", b.sel_active); end
        tick();
        n_chk++; if (b.dac_data !== {2{64'hFFFF_FFFF_FFFF_FFFF}}) begin
            n_fail++; $display("FAIL pn7_seed got %h exp all ones", b.dac_data); end
        tick();
        n_chk++; if (b.dac_data !== m_dac) begin n_fail++; $display("FAIL pn7_stream got %h exp %h", b.dac_data, m_dac); end
    endtask

    task automatic test_sync_wait();
        b.cfg_sel = 8'h03; b.cfg_sync_en = 1; b.cfg_update = 1; b.ext_sync = 1;
        tick();
        b.cfg_update = 0; b.ext_sync = 0;
        for (int i = 0; i < 10; i++) begin
            n_chk++; if (b.cfg_busy !== 1'b1 || b.sel_active !== 8'h22) begin
                n_fail++; $display("FAIL armed_hold[%0d] got busy=%b sel=%h exp 1/22", i, b.cfg_busy, b.sel_active); end
            tick();
        end
        b.ext_sync = 1;
        tick();
        b.ext_sync = 0;
        n_chk++; if (b.pn_reset !== 1'b1 || b.cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL sync_apply got pn_reset=%b busy=%b exp 1/1", b.pn_reset, b.cfg_busy); end
        tick();
        n_chk++; if (b.sel_active !== 8'h03 || b.cfg_busy !== 1'b0) begin
            n_fail++; $display("FAIL sync_done got sel=%h busy=%b exp 03/0", b.sel_active, b.cfg_busy); end
    endtask

    task automatic test_rearm_dma();
        logic [127:0] d;
        b.cfg_sel = 8'h33; b.cfg_sync_en = 1; b.cfg_update = 1;
        tick();
        b.cfg_update = 0;
        tick();
        b.cfg_sel = 8'h00; b.cfg_update = 1;
        tick();
        b.cfg_update = 0;
        n_chk++; if (b.cfg_busy !== 1'b1 || b.sel_active !== 8'h03) begin
            n_fail++; $display("FAIL rearm_hold got busy=%b sel=%h exp 1/03", b.cfg_busy, b.sel_active); end
        b.ext_sync = 1;
        tick();
        b.ext_sync = 0;
        n_chk++; if (b.pn_reset !== 1'b0) begin n_fail++; $display("FAIL rearm_pn_reset got %b exp 0", b.pn_reset); end
        tick();
        n_chk++; if (b.sel_active !== 8'h00 || b.dma_rd !== 1'b1) begin
            n_fail++; $display("FAIL rearm_dma got sel=%h rd=%b exp 00/1", b.sel_active, b.dma_rd); end
        d = b.dma_data;
        tick();
        n_chk++; if (b.dac_data !== d) begin n_fail++; $display("FAIL dma_latency got %h exp %h", b.dac_data, d); end
    endtask

    task automatic test_reserved();
        b.cfg_sel = 8'h5F; b.cfg_sync_en = 0; b.cfg_update = 1;
        tick();
        b.cfg_update = 0;
        n_chk++; if (b.pn_reset !== 1'b0) begin n_fail++; $display("FAIL reserved_pn_reset got %b exp 0", b.pn_reset); end
        tick();
        n_chk++; if (b.sel_active !== 8'h5F || b.dma_rd !== 1'b0) begin
            n_fail++; $display("FAIL reserved_sel got sel=%h rd=%b exp 5f/0", b.sel_active, b.dma_rd); end
        tick();
        n_chk++; if (b.dac_data !== 128'd0) begin n_fail++; $display("FAIL reserved_data got %h exp 0", b.dac_data); end
    endtask

    task automatic test_reset_armed();
        b.cfg_sel = 8'h22; b.cfg_sync_en = 1; b.cfg_update = 1;
        tick();
        b.cfg_update = 0;
        n_chk++; if (b.cfg_busy !== 1'b1) begin n_fail++; $display("FAIL rst_armed_busy got %b exp 1", b.cfg_busy); end
        #2 resetn = 0;
        model_reset();
        #1;
        n_chk++; if (b.cfg_busy !== 1'b0 || b.sel_active !== 8'h11 || b.pn_reset !== 1'b1 || b.dac_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async got busy=%b sel=%h pn=%b valid=%b exp 0/11/1/0",
                               b.cfg_busy, b.sel_active, b.pn_reset, b.dac_valid); end
        @(posedge clk);
        #1 resetn = 1;
        b.ext_sync = 1;
        tick();
        tick();
        b.ext_sync = 0;
        n_chk++; if (b.sel_active !== 8'h11 || b.cfg_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_pending_dropped got sel=%h busy=%b exp 11/0", b.sel_active, b.cfg_busy); end
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++) begin
                s[4*c +: 4] = 4'($urandom_range(0, 4));
                if (s[4*c +: 4] == 4'd4) s[4*c +: 4] = 4'($urandom_range(4, 15));
            end
            b.cfg_sel     = s;
            b.cfg_update  = ($urandom_range(0, 7) == 0);
            b.cfg_sync_en = 1'($urandom_range(0, 1));
            b.ext_sync    = ($urandom_range(0, 3) == 0);
            n_chk++; if (b.sel_active !== m_act) begin n_fail++; $display("FAIL rnd_sel[%0d] got %h exp %h", i, b.sel_active, m_act); end
            n_chk++; if (b.cfg_busy !== (m_wait || m_go)) begin n_fail++; $display("FAIL rnd_busy[%0d] got %b exp %b", i, b.cfg_busy, m_wait || m_go); end
            n_chk++; if (b.pn_reset !== exp_pnrst()) begin n_fail++; $display("FAIL rnd_pn_reset[%0d] got %b exp %b", i, b.pn_reset, exp_pnrst()); end
            n_chk++; if (b.dma_rd !== exp_dmard()) begin n_fail++; $display("FAIL rnd_dma_rd[%0d] got %b exp %b", i, b.dma_rd, exp_dmard()); end
            n_chk++; if (b.dac_data !== m_dac) begin n_fail++; $display("FAIL rnd_data[%0d] got %h exp %h", i, b.dac_data, m_dac); end
            n_chk++; if (b.dac_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, b.dac_valid, m_valid); end
            tick();
        end
        b.cfg_update = 0;
        b.ext_sync   = 0;
    endtask

    initial begin
        resetn        = 0;
        b.cfg_sel     = '0;
        b.cfg_update  = 0;
        b.cfg_sync_en = 0;
        b.ext_sync    = 0;
        b.pn7_data    = '0;
        b.pn15_data   = '0;
        b.dma_data    = '0;
        model_reset();
        test_reset();
        test_pn7_switch();
        test_sync_wait();
        test_rearm_dma();
        test_reserved();
        test_reset_armed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
